mem_access_stage: RTL
=====================

# mem_access_stage

Data-memory access stage of the pipelined processor: sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It performs loads and stores over a req/ack data-memory bus, sign- or zero-extends load data, and presents ALU result, load data, destination address and writeback controls to MEM/WB. Non-memory instructions pass through combinationally. Memory instructions stall the upstream pipeline until the bus completes or times out.

## Interface
- TIMEOUT_CYCLES, 255: max BUSY cycles before abort; 0 disables the timeout; valid range 0–255 (8-bit counter).
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  store source (rs2 value)
- ex_rd_address  in  5  destination register
- ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite  in  1 each  controls
- ex_size  in  2  00 byte, 01 half, 10/11 word
- ex_unsigned  in  1  zero-extend loads when 1
- stall_out  out  1  hold EX/MEM and earlier stages
- dmem_req, dmem_we  out  1  bus request / write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  single-cycle completion
- dmem_rdata  in  32  read word, valid with ack
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each
- wb_alu_data, wb_data  out  32
- wb_rd_address  out  5
- bus_err, misalign_err  out  1  one-cycle error pulses, coincident with wb_valid

## Operation
- FSM: IDLE, BUSY, DONE. Reset -> IDLE, dmem_req=0, timeout counter=0, all latched fields=0; all outputs 0 while reset is asserted or while IDLE with ex_valid=0.
- IDLE, ex_valid, no MemRead/MemWrite: wb_* = ex_* combinationally, wb_data=0, wb_valid=1, stall_out=0.
- IDLE, ex_valid with MemRead or MemWrite: latch all ex fields, stall_out=1, go BUSY. MemRead and MemWrite both set is treated as a store.
- BUSY: dmem_req=1 (registered), stall_out=1, counter increments. On dmem_ack: capture extended load data, go DONE. If counter reaches TIMEOUT_CYCLES without ack: drop the request, go DONE with bus_err pending.
- DONE: wb_valid=1, wb_* from latched fields, stall_out=0, go IDLE. On error, wb_RegWrite=0 and wb_data=0.
- Byte lanes: byte uses addr[1:0]; half uses addr[1]. Store dmem_be = 0001<<addr[1:0] (byte), 0011<<{addr[1],1'b0} (half), 1111 (word). dmem_wdata holds the byte or half replicated across all lanes.
- Load extension: the selected lane is extended to 32 bits, sign-extended unless ex_unsigned=1. dmem_rdata is ignored for stores.
- Upstream holds ex_* stable while stall_out=1; inputs are sampled only in IDLE.

## Timing
- Pass-through: 0-cycle latency, one instruction per cycle.
- Memory op: accept in cycle 0, dmem_req from cycle 1, earliest ack in cycle 1, wb_valid in cycle 2. Minimum 3 cycles per memory op; 2 stall cycles.
- dmem_req deasserts in the cycle after ack is sampled.
- Ack arriving in the same cycle the counter hits its limit counts as success.
- Reset mid-BUSY: dmem_req drops immediately and the transaction is abandoned; the memory must tolerate this.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a misaligned half (addr[0]=1) or word (addr[1:0]!=0) access in IDLE issues no bus request. It completes combinationally with wb_valid=1, misalign_err=1, wb_RegWrite=0, stall_out=0.
- Not defined: misaligned addresses are truncated to the word address and lanes are selected from the low address bits as usual; misalign_err is tied to 0.

## Test plan
- ALU op: ex_alu_result=0x1234, rd=5, RegWrite=1 -> same cycle wb_valid=1, wb_alu_data=0x1234, stall_out=0.
- Load byte signed at 0x103, ack in cycle 1 with rdata=0x80FF_FF7F -> cycle 2 wb_data=0xFFFF_FF80, wb_MemtoReg=1; stall_out high in cycles 0–1.
- Store half 0xBEEF at 0x102 -> dmem_addr=0x100, be=1100, wdata=0xBEEF_BEEF, dmem_we=1; ack delayed 4 cycles -> wb_valid in cycle 6.
- TIMEOUT_CYCLES=3, no ack -> bus_err=1 with wb_valid, wb_RegWrite=0, dmem_req low afterwards.
- Reset asserted during BUSY -> dmem_req=0 and stall_out=0 immediately; next load completes normally.
- With MEM_ALIGN_CHECK_EN, load word at 0x2 -> no dmem_req, misalign_err=1 in the same cycle; without it -> dmem_addr=0x0 and a normal load.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Data-memory access stage between the EX/MEM and MEM/WB pipeline registers.
// Non-memory instructions pass straight through in the same cycle. Loads and
// stores are latched, stall the upstream pipeline, run one transaction on a
// req/ack data bus, and are written back one cycle after the bus completes
// or times out. Load data is lane-selected and sign/zero-extended. Store
// data is replicated across byte lanes and qualified by byte enables.
//
// Configuration macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses complete at once with
//               misalign_err and never reach the bus
//   undefined : misaligned addresses are truncated to the word address;
//               misalign_err stays 0
//
// Parameter:
//   TIMEOUT_CYCLES  max bus cycles without ack before abort (0 = never, <=255)
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   ex_valid                   EX/MEM holds a valid instruction
//   ex_alu_result              ALU result / effective address
//   ex_store_data              store source value
//   ex_rd_address              destination register
//   ex_RegWrite, ex_MemtoReg,
//   ex_MemRead, ex_MemWrite    pipeline controls
//   ex_size                    00 byte, 01 half, 1x word
//   ex_unsigned                zero-extend loads
//   stall_out                  hold EX/MEM and earlier stages
//   dmem_req, dmem_we          bus request / write strobe
//   dmem_addr                  word-aligned bus address
//   dmem_wdata, dmem_be        replicated store data, byte enables
//   dmem_ack, dmem_rdata       single-cycle completion, read word
//   wb_valid, wb_RegWrite,
//   wb_MemtoReg, wb_alu_data,
//   wb_data, wb_rd_address     values presented to MEM/WB
//   bus_err, misalign_err      one-cycle error pulses alongside wb_valid

module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd_address,
  input  logic        ex_RegWrite,
  input  logic        ex_MemtoReg,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_alu_data,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_address,
  output logic        bus_err,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;

  logic [31:0] lat_alu;
  logic [31:0] lat_store_data;
  logic [4:0]  lat_rd;
  logic        lat_reg_write;
  logic        lat_mem_to_reg;
  logic        lat_is_store;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] load_data;
  logic        err_pending;
  logic [7:0]  busy_count;

  logic        is_mem;
  logic        misaligned;
  logic        accept;
  logic        timeout_hit;

  // Selects the addressed lane of a read word and extends it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  size,
                                              input logic        zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return zero_ext ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return zero_ext ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lo,
                                          input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // The memory picks the lane it needs via dmem_be, so sub-word store data
  // is simply repeated on every lane.
  function automatic logic [31:0] store_lanes(input logic [31:0] data,
                                              input logic [1:0]  size);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  assign is_mem = ex_MemRead | ex_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((ex_size == 2'b01) && ex_alu_result[0]) ||
                      (ex_size[1] && (ex_alu_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept = (state == IDLE) && ex_valid && is_mem && !misaligned;

  // busy_count holds the number of bus cycles already completed, so the
  // current cycle is the last allowed one when count+1 equals the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((busy_count + 8'd1) == 8'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and all outputs. Everything is forced low while reset is
  // asserted, including the combinational pass-through path.
  always_comb begin
    state_next    = state;
    stall_out     = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = 32'b0;
    dmem_wdata    = 32'b0;
    dmem_be       = 4'b0;
    wb_valid      = 1'b0;
    wb_RegWrite   = 1'b0;
    wb_MemtoReg   = 1'b0;
    wb_alu_data   = 32'b0;
    wb_data       = 32'b0;
    wb_rd_address = 5'b0;
    bus_err       = 1'b0;
    misalign_err  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) state_next = BUSY;
        if (!reset && ex_valid) begin
          if (!is_mem) begin
            wb_valid      = 1'b1;
            wb_RegWrite   = ex_RegWrite;
            wb_MemtoReg   = ex_MemtoReg;
            wb_alu_data   = ex_alu_result;
            wb_rd_address = ex_rd_address;
`ifdef MEM_ALIGN_CHECK_EN
          end else if (misaligned) begin
            wb_valid      = 1'b1;
            wb_MemtoReg   = ex_MemtoReg;
            wb_alu_data   = ex_alu_result;
            wb_rd_address = ex_rd_address;
            misalign_err  = 1'b1;
`endif
          end else begin
            stall_out = 1'b1;
          end
        end
      end

      BUSY: begin
        if (dmem_ack || timeout_hit) state_next = DONE;
        if (!reset) begin
          stall_out  = 1'b1;
          dmem_req   = 1'b1;
          dmem_we    = lat_is_store;
          dmem_addr  = {lat_alu[31:2], 2'b00};
          dmem_wdata = store_lanes(lat_store_data, lat_size);
          dmem_be    = store_be(lat_alu[1:0], lat_size);
        end
      end

      DONE: begin
        state_next = IDLE;
        if (!reset) begin
          wb_valid      = 1'b1;
          wb_RegWrite   = lat_reg_write & ~err_pending;
          wb_MemtoReg   = lat_mem_to_reg;
          wb_alu_data   = lat_alu;
          wb_data       = err_pending ? 32'b0 : load_data;
          wb_rd_address = lat_rd;
          bus_err       = err_pending;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: latch the instruction on accept, count bus
  // cycles, and capture extended read data or a timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_alu        <= 32'b0;
      lat_store_data <= 32'b0;
      lat_rd         <= 5'b0;
      lat_reg_write  <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      lat_is_store   <= 1'b0;
      lat_size       <= 2'b0;
      lat_unsigned   <= 1'b0;
      load_data      <= 32'b0;
      err_pending    <= 1'b0;
      busy_count     <= 8'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_alu        <= ex_alu_result;
            lat_store_data <= ex_store_data;
            lat_rd         <= ex_rd_address;
            lat_reg_write  <= ex_RegWrite;
            lat_mem_to_reg <= ex_MemtoReg;
            lat_is_store   <= ex_MemWrite;
            lat_size       <= ex_size;
            lat_unsigned   <= ex_unsigned;
            load_data      <= 32'b0;
            err_pending    <= 1'b0;
            busy_count     <= 8'b0;
          end
        end
        BUSY: begin
          busy_count <= busy_count + 8'd1;
          if (dmem_ack) begin
            if (!lat_is_store)
              load_data <= extend_load(dmem_rdata, lat_alu[1:0], lat_size, lat_unsigned);
          end else if (timeout_hit) begin
            err_pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
